// File: rtl/dart_turn_sched.sv
// Throw scheduler in front of the dart scoring core: arbitrates two player
// channels by turn order, serialises throws, and injects misses on idle timeout.
module dart_turn_sched #(
  parameter int TURN_DARTS     = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int INIT_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_req_i,
  input  logic [7:0] p1_x_i,
  input  logic [7:0] p1_y_i,
  output logic       p1_ack_o,
  input  logic       p2_req_i,
  input  logic [7:0] p2_x_i,
  input  logic [7:0] p2_y_i,
  output logic       p2_ack_o,
  output logic       dart_come_o,
  output logic [7:0] dart_position_x_o,
  output logic [7:0] dart_position_y_o,
  input  logic       player_1_done_i,
  input  logic       player_2_done_i,
  input  logic       game_set_i,
  output logic       turn_o,
  output logic [1:0] dart_idx_o,
  output logic       ready_o,
  output logic       timeout_o,
  output logic       game_over_o,
  output logic       error_o,
  output logic [2:0] dbg_state_o
);

  // Player handshake: a player raises req with stable x/y and holds both until
  // its one-cycle ack; the ack cycle is the cycle the throw is strobed to the core.

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_WAIT_REQ  = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam bit          TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [15:0] TO_LAST   = (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
  localparam logic [15:0] INIT_LAST = (INIT_CYCLES > 1) ? 16'(INIT_CYCLES - 1) : 16'd0;
  localparam logic [1:0]  IDX_LAST  = 2'(TURN_DARTS - 1);

  state_t      state_q, state_d;
  logic [15:0] init_cnt_q, init_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [7:0]  pos_x_q, pos_x_d;
  logic [7:0]  pos_y_q, pos_y_d;
  logic        turn_q, turn_d;
  logic [1:0]  idx_q, idx_d;
  logic        miss_q, miss_d;
  logic        error_q, error_d;
  logic        p1_ack_q, p1_ack_d;
  logic        p2_ack_q, p2_ack_d;
  logic        dart_come_q, dart_come_d;
  logic        timeout_q, timeout_d;
  logic        ready_q, ready_d;
  logic        game_over_q, game_over_d;

  logic       active_req;
  logic [7:0] active_x;
  logic [7:0] active_y;
  logic       active_done;
  logic       inactive_done;
  logic       any_done;
  logic       issue_next;

  always_comb begin
    active_req    = turn_q ? p2_req_i : p1_req_i;
    active_x      = turn_q ? p2_x_i : p1_x_i;
    active_y      = turn_q ? p2_y_i : p1_y_i;
    active_done   = turn_q ? player_2_done_i : player_1_done_i;
    inactive_done = turn_q ? player_1_done_i : player_2_done_i;
    any_done      = player_1_done_i | player_2_done_i;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    to_cnt_d   = to_cnt_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    turn_d     = turn_q;
    idx_d      = idx_q;
    miss_d     = miss_q;
    error_d    = error_q;

    if (inactive_done || (any_done && (state_q != ST_WAIT_DONE))) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q >= INIT_LAST) begin
          state_d  = ST_WAIT_REQ;
          to_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 16'd1;
        end
      end
      ST_WAIT_REQ: begin
        // A real request beats a timeout landing on the same cycle.
        if (active_req) begin
          pos_x_d = active_x;
          pos_y_d = active_y;
          miss_d  = 1'b0;
          state_d = ST_ISSUE;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          pos_x_d = 8'd0;
          pos_y_d = 8'd0;
          miss_d  = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (active_done) begin
          if (idx_q == IDX_LAST) begin
            idx_d  = 2'd0;
            turn_d = ~turn_q;
          end else begin
            idx_d = idx_q + 2'd1;
          end
          to_cnt_d = '0;
          state_d  = ST_WAIT_REQ;
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Game set wins over everything else; a coinciding done is still counted above.
    if (game_set_i && (state_q != ST_INIT)) begin
      state_d = ST_OVER;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
    end

    issue_next  = (state_d == ST_ISSUE);
    dart_come_d = issue_next;
    timeout_d   = issue_next & miss_d;
    p1_ack_d    = issue_next & ~miss_d & ~turn_d;
    p2_ack_d    = issue_next & ~miss_d & turn_d;
    ready_d     = (state_d == ST_WAIT_REQ);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      to_cnt_q    <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      turn_q      <= 1'b0;
      idx_q       <= '0;
      miss_q      <= 1'b0;
      error_q     <= 1'b0;
      p1_ack_q    <= 1'b0;
      p2_ack_q    <= 1'b0;
      dart_come_q <= 1'b0;
      timeout_q   <= 1'b0;
      ready_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      turn_q      <= turn_d;
      idx_q       <= idx_d;
      miss_q      <= miss_d;
      error_q     <= error_d;
      p1_ack_q    <= p1_ack_d;
      p2_ack_q    <= p2_ack_d;
      dart_come_q <= dart_come_d;
      timeout_q   <= timeout_d;
      ready_q     <= ready_d;
      game_over_q <= game_over_d;
    end
  end

  assign p1_ack_o          = p1_ack_q;
  assign p2_ack_o          = p2_ack_q;
  assign dart_come_o       = dart_come_q;
  assign dart_position_x_o = pos_x_q;
  assign dart_position_y_o = pos_y_q;
  assign turn_o            = turn_q;
  assign dart_idx_o        = idx_q;
  assign ready_o           = ready_q;
  assign timeout_o         = timeout_q;
  assign game_over_o       = game_over_q;
  assign error_o           = error_q;
  assign dbg_state_o       = state_q;

endmodule

// File: doc/dart_turn_sched.md
# dart_turn_sched

Throw scheduler that sits in front of the `dart` scoring core and shares its single throw port between two player input channels. It enforces turn order and darts-per-turn, and serialises one throw at a time into the core. It keeps its own turn/dart bookkeeping in lock-step with the core and injects zero-score "miss" throws when the active player times out. It stops accepting throws once the core reports game set.

## Interface
- `TURN_DARTS`, 3, darts per turn; must equal the core's per-turn count.
- `TIMEOUT_CYCLES`, 1000, max cycles the active player may idle in WAIT_REQ before a miss is injected; 0 disables. Counter is 16 bits.
- `INIT_CYCLES`, 2, cycles held in INIT after reset release while the core runs START→INITIALIZE.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `p1_req_i`  in  1  player 1 throw request; held with data until ack.
- `p1_x_i`, `p1_y_i`  in  8 each  player 1 dart coordinates.
- `p1_ack_o`  out  1  one-cycle pulse: player 1 throw accepted.
- `p2_req_i`, `p2_x_i`, `p2_y_i`, `p2_ack_o`  same for player 2.
- `dart_come_o`  out  1  one-cycle throw strobe to the core.
- `dart_position_x_o`, `dart_position_y_o`  out  8 each  registered coordinates to the core.
- `player_1_done_i`, `player_2_done_i`  in  1  core per-throw done pulses.
- `game_set_i`  in  1  core game-set indication.
- `turn_o`  out  1  active player: 0 = P1, 1 = P2.
- `dart_idx_o`  out  2  darts already completed in the current turn.
- `ready_o`  out  1  high in WAIT_REQ.
- `timeout_o`  out  1  one-cycle pulse: an injected miss is being issued.
- `game_over_o`  out  1  high in OVER.
- `error_o`  out  1  sticky protocol error.

## Operation
- States: INIT, WAIT_REQ, ISSUE, WAIT_DONE, OVER.
- INIT: count `INIT_CYCLES`, then go to WAIT_REQ.
- WAIT_REQ: sample only the active player's req (P1 when `turn_o`=0, P2 when 1).
  - The inactive player's req is ignored: no ack, and its data is held.
  - On an active req: latch x/y into the output registers and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `dart_come_o`=1.
  - The active player's ack = 1, unless this is an injected miss.
  - Then go to WAIT_DONE.
- WAIT_DONE: wait for the done pulse of the active player.
  - On that done: if `dart_idx_o`=`TURN_DARTS`-1, set `dart_idx_o`←0 and toggle `turn_o`; else `dart_idx_o`+1.
  - Then go to WAIT_REQ.
- Timeout: the counter clears on every entry to WAIT_REQ and increments each cycle spent there.
  - At count `TIMEOUT_CYCLES`-1 with no active req: latch (0,0) — a zero-score cell — and go to ISSUE with `timeout_o`=1 and no ack.
  - If a req and the timeout coincide, the req wins.
- `game_set_i` high in any state except INIT → OVER, including when it coincides with done. The done is still counted in `dart_idx_o`/`turn_o`.
- OVER: terminal until reset; no acks, `dart_come_o`=0.
- `error_o` sets on either of:
  - a done from the inactive player;
  - any done outside WAIT_DONE.
  - The error does not change the state flow.

## Timing
- Reset (async assert) values:
  - state=INIT;
  - all outputs 0, including coordinates, `turn_o`, `dart_idx_o` and `error_o`.
- Reset deassertion is synchronous to `clk`. A reset in mid-operation returns to INIT and discards any latched throw.
- Acks, `dart_come_o` and `timeout_o` are decoded from registered state: glitch-free, exactly one cycle each.
- Req sampled at edge E0 → ISSUE during E0..E1 → core sees the strobe at E1 → core done arrives during E3..E4 → WAIT_REQ after E4.
- Minimum throw-to-throw spacing is 5 cycles.
- `dart_idx_o`/`turn_o` update at the same edge that samples done.
- Coordinates stay stable from ISSUE until the next latch.
- `ready_o` goes high `INIT_CYCLES` cycles after reset release.

## Test plan
- **Reset and init:** assert reset, release → all outputs 0; `ready_o`=1 exactly 2 cycles later with `turn_o`=0.
- **Single throw:** P1 req (x=15, y=15) → `p1_ack_o` and `dart_come_o` pulse in the same cycle with coordinates 15/15 → core P1 score 501→451 → `dart_idx_o`=1.
- **Turn change:** three P1 throws complete → `turn_o`=1, `dart_idx_o`=0. A P2 req held during P1's turn gets no ack until then, and is acked in the first ISSUE afterwards.
- **Timeout:** `TIMEOUT_CYCLES`=8, no req → `timeout_o` pulse 8 cycles after entering WAIT_REQ, coordinates (0,0), no ack, score unchanged, `dart_idx_o` increments.
- **Game set:** drive P1 score to 0 → `game_set_i` coincides with done → `game_over_o`=1; further reqs get no ack and no `dart_come_o`.
- **Error and reset:** `player_2_done_i` during P1 WAIT_DONE → `error_o`=1 and stays high. Then reset in WAIT_DONE → INIT, `error_o`=0, outputs cleared.
